mem_access_ctrl: RTL and testbench

Load/store controller for the MEM stage of the pipelined datapath. It turns byte, halfword and word load/store requests into word-aligned accesses on the 1 KB byte-array data memory's word port. That port has a combinational read, a posedge write, and little-endian byte order. Sub-word stores use a read-modify-write sequence; misaligned and out-of-range accesses are flagged and never reach memory.

---
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: turns byte/half/word requests into word-aligned
// accesses, with read-modify-write for sub-word stores and early error rejection.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Ready,
    output logic        Done,
    output logic        AddrErr,
    output logic [31:0] LoadData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWd,
    input  logic [31:0] MemRd
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    typedef enum logic [2:0] {
        OP_LB = 3'b000, OP_LH = 3'b001, OP_LW = 3'b010, OP_LBU = 3'b011,
        OP_LHU = 3'b100, OP_SB = 3'b101, OP_SH = 3'b110, OP_SW = 3'b111
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [1:0]  k_q, k_d;
    logic [15:0] sdata_q, sdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        addr_err;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] merged;

    always_comb begin
        addr_err = (Addr >= 32'(MEM_BYTES));
        unique case (op_t'(Op))
            OP_LW, OP_SW:         if (Addr[1:0] != 2'b00) addr_err = 1'b1;
            OP_LH, OP_LHU, OP_SH: if (Addr[0]) addr_err = 1'b1;
            default: ;
        endcase
    end

    // Lane selection and merge are driven by the latched offset, not the live request.
    always_comb begin
        bsel   = MemRd[{k_q, 3'b000} +: 8];
        hsel   = MemRd[{k_q[1], 4'b0000} +: 16];
        merged = MemRd;
        if (op_q == OP_SB) merged[{k_q, 3'b000} +: 8] = sdata_q[7:0];
        else               merged[{k_q[1], 4'b0000} +: 16] = sdata_q;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        k_d         = k_q;
        sdata_d     = sdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wd_d    = mem_wd_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Req) begin
                    if (addr_err) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        op_d       = op_t'(Op);
                        k_d        = Addr[1:0];
                        sdata_d    = StoreData[15:0];
                        mem_addr_d = {Addr[31:2], 2'b00};
                        if (op_t'(Op) == OP_SW) begin
                            mem_wd_d = StoreData;
                            state_d  = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                if (op_q == OP_SB || op_q == OP_SH) begin
                    mem_wd_d = merged;
                    state_d  = WR;
                end else begin
                    unique case (op_q)
                        OP_LB:   load_data_d = {{24{bsel[7]}}, bsel};
                        OP_LBU:  load_data_d = {24'h0, bsel};
                        OP_LH:   load_data_d = {{16{hsel[15]}}, hsel};
                        OP_LHU:  load_data_d = {16'h0, hsel};
                        default: load_data_d = MemRd;
                    endcase
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            op_q        <= OP_LB;
            k_q         <= 2'b00;
            sdata_q     <= 16'h0;
            mem_addr_q  <= 32'h0;
            mem_wd_q    <= 32'h0;
            load_data_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            k_q         <= k_d;
            sdata_q     <= sdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wd_q    <= mem_wd_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign Ready    = (state_q == IDLE);
    assign Done     = done_q;
    assign AddrErr  = err_q;
    assign LoadData = load_data_q;
    assign MemRead  = (state_q == RD);
    assign MemWrite = (state_q == WR);
    assign MemAddr  = mem_addr_q;
    assign MemWd    = mem_wd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected completions,
// a negedge monitor pops and checks them whenever Done is seen.
module tb_mem_access_ctrl;
    localparam int MEM_BYTES = 1024;

    logic        Clk = 1'b0;
    logic        Rst, Req;
    logic [2:0]  Op;
    logic [31:0] Addr, StoreData;
    logic        Ready, Done, AddrErr, MemRead, MemWrite;
    logic [31:0] LoadData, MemAddr, MemWd, MemRd;

    mem_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Op(Op), .Addr(Addr), .StoreData(StoreData),
        .Ready(Ready), .Done(Done), .AddrErr(AddrErr), .LoadData(LoadData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWd(MemWd),
        .MemRd(MemRd)
    );

    always #5 Clk = ~Clk;

    // Byte-array memory, little-endian word port
    logic [7:0] mem [MEM_BYTES];
    logic [9:0] wa;
    assign wa    = {MemAddr[9:2], 2'b00};
    assign MemRd = {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};
    always @(posedge Clk) begin
        if (MemWrite) begin
            mem[wa]         <= MemWd[7:0];
            mem[wa + 10'd1] <= MemWd[15:8];
            mem[wa + 10'd2] <= MemWd[23:16];
            mem[wa + 10'd3] <= MemWd[31:24];
        end
    end

    function automatic logic [31:0] word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: Done=1 with no pending request (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("addr_err", {31'h0, AddrErr}, {31'h0, e.err});
                chk("load_data", LoadData, e.ld);
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1 with Req still high.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic err, input logic [31:0] ld, input int lat,
                         input bit push, output int pc);
        int n;
        exp_t e;
        n = 0;
        Req = 1'b1; Op = op; Addr = a; StoreData = sd;
        while (Ready !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            $display("FAIL ready_timeout: Ready stayed low for op %b addr %h", op, a);
        end
        pc = cyc;
        if (push) begin
            e.err = err; e.ld = ld; e.cyc = cyc + lat;
            sb_q.push_back(e);
        end
        @(negedge Clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        Req = 1'b0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL done_timeout: %0d completions missing", sb_q.size());
            sb_q.delete();
        end
        @(negedge Clk);
    endtask

    task automatic load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
        int pc;
        issue(op, a, 32'h0, 1'b0, exp, 2, 1'b1, pc);
        Req = 1'b0;
        drain();
    endtask

    task automatic bad(input logic [2:0] op, input logic [31:0] a, input logic [31:0] ld);
        int pc;
        issue(op, a, 32'hDEADBEEF, 1'b1, ld, 1, 1'b1, pc);
        Req = 1'b0;
        chk("err_no_mem_access", {30'h0, MemRead, MemWrite}, 32'h0);
        drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},    {31'h0, Ready},    32'h1);
        chk({tag, "_done"},     {31'h0, Done},     32'h0);
        chk({tag, "_addrerr"},  {31'h0, AddrErr},  32'h0);
        chk({tag, "_loaddata"}, LoadData,          32'h0);
        chk({tag, "_memread"},  {31'h0, MemRead},  32'h0);
        chk({tag, "_memwrite"}, {31'h0, MemWrite}, 32'h0);
        chk({tag, "_memaddr"},  MemAddr,           32'h0);
        chk({tag, "_memwd"},    MemWd,             32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pc, pc2;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        mem[16] = 8'h55; mem[17] = 8'h66; mem[18] = 8'h77; mem[19] = 8'h88;
        Rst = 1'b1; Req = 1'b0; Op = 3'b000; Addr = 32'h0; StoreData = 32'h0;
        repeat (3) @(negedge Clk);
        chk_reset_outputs("reset");
        Rst = 1'b0;
        @(negedge Clk);

        // LW with per-cycle port checks
        issue(3'b010, 32'h10, 32'h0, 1'b0, 32'h88776655, 2, 1'b1, pc);
        Req = 1'b0;
        chk("lw_c1_memread", {31'h0, MemRead}, 32'h1);
        chk("lw_c1_memaddr", MemAddr, 32'h10);
        chk("lw_c1_memwrite", {31'h0, MemWrite}, 32'h0);
        @(negedge Clk);
        chk("lw_c2_memread", {31'h0, MemRead}, 32'h0);
        drain();

        load(3'b000, 32'h13, 32'hFFFFFF88);   // LB
        load(3'b011, 32'h13, 32'h00000088);   // LBU
        load(3'b001, 32'h12, 32'hFFFF8877);   // LH
        load(3'b100, 32'h10, 32'h00006655);   // LHU

        // SB read-modify-write
        issue(3'b101, 32'h11, 32'h000000AB, 1'b0, 32'h00006655, 3, 1'b1, pc);
        Req = 1'b0;
        chk("sb_c1_memread", {31'h0, MemRead}, 32'h1);
        chk("sb_c1_memwrite", {31'h0, MemWrite}, 32'h0);
        @(negedge Clk);
        chk("sb_c2_memwrite", {31'h0, MemWrite}, 32'h1);
        chk("sb_c2_memwd", MemWd, 32'h8877AB55);
        drain();

        issue(3'b110, 32'h12, 32'h00001234, 1'b0, 32'h00006655, 3, 1'b1, pc);
        Req = 1'b0;
        @(negedge Clk);
        chk("sh_c2_memwd", MemWd, 32'h1234AB55);
        drain();

        load(3'b000, 32'h3FF, 32'h00000000);  // LB at last valid byte
        load(3'b000, 32'h12, 32'h00000034);   // LB positive byte
        load(3'b001, 32'h10, 32'hFFFFAB55);   // LH
        load(3'b010, 32'h10, 32'h1234AB55);   // LW after RMW stores

        bad(3'b010, 32'h12, 32'h1234AB55);    // LW misaligned
        bad(3'b001, 32'h11, 32'h1234AB55);    // LH misaligned
        bad(3'b111, 32'h400, 32'h1234AB55);   // SW out of range
        bad(3'b000, 32'h400, 32'h1234AB55);   // LB out of range
        chk("err_mem_word0", word(0), 32'h0);
        chk("err_mem_word10", word(16), 32'h1234AB55);

        // SW direct write
        issue(3'b111, 32'h18, 32'hCAFEF00D, 1'b0, 32'h1234AB55, 2, 1'b1, pc);
        Req = 1'b0;
        chk("sw_c1_memwrite", {31'h0, MemWrite}, 32'h1);
        chk("sw_c1_memwd", MemWd, 32'hCAFEF00D);
        drain();
        load(3'b010, 32'h18, 32'hCAFEF00D);

        // Back to back: SB then LW with Req held high
        issue(3'b101, 32'h14, 32'h000000CD, 1'b0, 32'hCAFEF00D, 3, 1'b1, pc);
        chk("b2b_c1_ready", {31'h0, Ready}, 32'h0);
        issue(3'b010, 32'h14, 32'h0, 1'b0, 32'h000000CD, 2, 1'b1, pc2);
        Req = 1'b0;
        chk("b2b_accept_gap", pc2 - pc, 32'd3);
        drain();

        // Reset during RD of SB aborts with no write and no Done
        issue(3'b101, 32'h10, 32'h000000EE, 1'b0, 32'h0, 3, 1'b0, pc);
        Req = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        chk_reset_outputs("rst_abort");
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_mem_word10", word(16), 32'h1234AB55);
        load(3'b010, 32'h10, 32'h1234AB55);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
